// File: rtl/volume_meter.sv
// Volume meter: windowed peak amplitude of 12-bit mic samples with
// peak-hold and one-step-per-window decay, shown as a 16-bit thermometer.
module volume_meter #(
    parameter int WINDOW       = 4000,
    parameter int OFFSET       = 2048,
    parameter int HOLD_WINDOWS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] mic_in,
    input  logic        sample_valid,
    input  logic        freeze,
    output logic [15:0] led_light,
    output logic [4:0]  level,
    output logic        update
);

    localparam int              CW        = $clog2(WINDOW);
    localparam logic [CW-1:0]   LAST      = CW'(WINDOW - 1);
    localparam logic [11:0]     MID       = 12'(OFFSET);
    localparam logic [7:0]      HOLD_INIT = 8'(HOLD_WINDOWS);

    typedef enum logic [1:0] {TRACK, HOLD, DECAY} state_t;

    logic [11:0]   amp;
    logic [4:0]    q_raw;
    logic [4:0]    q;
    logic [4:0]    peak;
    logic [4:0]    peak_next;
    logic [CW-1:0] cnt;
    logic [4:0]    win_level;
    logic          closed;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    hold_cnt;
    logic [7:0]    hold_nx;
    logic [4:0]    disp_nx;
    logic [16:0]   therm;

    always_comb begin
        amp       = (mic_in >= MID) ? (mic_in - MID) : (MID - mic_in);
        q_raw     = 5'(amp >> 7);
        q         = (q_raw > 5'd16) ? 5'd16 : q_raw;
        peak_next = (q > peak) ? q : peak;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            peak      <= '0;
            win_level <= '0;
            closed    <= 1'b0;
        end else begin
            closed <= 1'b0;
            if (sample_valid) begin
                if (cnt == LAST) begin
                    win_level <= peak_next;
                    peak      <= '0;
                    cnt       <= '0;
                    closed    <= 1'b1;
                end else begin
                    peak <= peak_next;
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end

    // level doubles as the displayed value; this is its next value on a close
    always_comb begin
        disp_nx  = level;
        state_nx = state;
        hold_nx  = hold_cnt;
        if (win_level >= level) begin
            disp_nx  = win_level;
            hold_nx  = HOLD_INIT;
            state_nx = (HOLD_WINDOWS == 0) ? TRACK : HOLD;
        end else if (state == HOLD) begin
            if (hold_cnt > 8'd1)
                hold_nx = hold_cnt - 8'd1;
            else
                state_nx = DECAY;
        end else begin
            disp_nx  = level - 5'd1;
            state_nx = (disp_nx == win_level) ? TRACK : DECAY;
        end
        therm = (17'd1 << disp_nx) - 17'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= TRACK;
            hold_cnt  <= '0;
            level     <= '0;
            led_light <= '0;
            update    <= 1'b0;
        end else begin
            update <= 1'b0;
            if (closed && !freeze) begin
                state     <= state_nx;
                hold_cnt  <= hold_nx;
                level     <= disp_nx;
                led_light <= therm[15:0];
                update    <= 1'b1;
            end
        end
    end

endmodule
